note_acceptor: RTL and testbench

Cash-acceptor front end that sits directly upstream of the bill-payment controller and produces its 10-bit inserted-amount input. It debounces the slot optical sensor, measures note length, classifies the denomination code, and presents one validated amount per note with a valid/ack handshake. Invalid, mis-sized or abandoned notes are ejected. Accepted-note count and running total are kept for the receipt stage.

---
 rtl/note_acceptor.sv | 220 ++++++++++++++++++++++
 tb/tb_note_acceptor.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_acceptor.sv
// ---------------------------------------------------------------------------
// note_acceptor
//   Cash-acceptor front end. Debounces the slot optical sensor, measures the
//   note length in high samples, classifies the denomination code and offers
//   one validated amount per note to the bill-payment controller through a
//   valid/ack handshake. Invalid, mis-sized or abandoned notes are ejected.
//   Accepted-note count, ejected-note count and the running total are kept
//   for the receipt stage.
//
// Parameters
//   DEB      consecutive high samples before a note is treated as real
//   LEN_MIN  minimum accepted note length (high samples)
//   LEN_MAX  maximum accepted note length (high samples)
//   REJ_CYC  cycles reject is held high per ejection
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-low reset
//   enable      cash mode active; starts acceptance and keeps an escrowed note
//   note_sense  slot sensor, high while a note blocks it
//   note_code   denomination code (0 invalid, 1..7 -> 5..1000)
//   ack         consumer has taken IA
//   clr         synchronous clear of the counters (new session)
//   IA          accepted note value, 0 when not valid
//   ia_valid    IA valid, held until ack
//   reject      eject motor drive
//   busy        state is not IDLE
//   note_cnt    accepted notes, wraps at 256
//   rej_cnt     ejected notes, wraps at 256
//   total       sum of accepted values, saturates at 16383
// ---------------------------------------------------------------------------
module note_acceptor #(
  parameter int unsigned DEB     = 4,
  parameter int unsigned LEN_MIN = 40,
  parameter int unsigned LEN_MAX = 200,
  parameter int unsigned REJ_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        note_sense,
  input  logic [2:0]  note_code,
  input  logic        ack,
  input  logic        clr,
  output logic [9:0]  IA,
  output logic        ia_valid,
  output logic        reject,
  output logic        busy,
  output logic [7:0]  note_cnt,
  output logic [7:0]  rej_cnt,
  output logic [13:0] total
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_MEASURE,
    S_CLASSIFY,
    S_PRESENT,
    S_REJECT
  } state_t;

  localparam int unsigned RW = $clog2(REJ_CYC + 1);
  localparam logic [RW-1:0] REJ_LAST = RW'(REJ_CYC - 1);

  state_t          state;
  logic [7:0]      len;
  logic [2:0]      code_q;
  logic [RW-1:0]   rcnt;
  // Sensor sampled low on the previous edge. Cleared by reset so a note
  // already in the slot at reset release cannot look like a fresh rise.
  logic            prev_low;

  logic [7:0]      len_inc;
  logic            note_ok;
  logic            accept;
  logic            rej_done;
  logic [14:0]     total_sum;
  logic [13:0]     total_acc;

  function automatic logic [9:0] decode(input logic [2:0] c);
    case (c)
      3'd1:    decode = 10'd5;
      3'd2:    decode = 10'd10;
      3'd3:    decode = 10'd20;
      3'd4:    decode = 10'd50;
      3'd5:    decode = 10'd100;
      3'd6:    decode = 10'd500;
      3'd7:    decode = 10'd1000;
      default: decode = 10'd0;
    endcase
  endfunction

  always_comb begin
    len_inc   = (len == 8'hFF) ? len : len + 8'd1;
    // A saturated length means the real note was longer than 255 samples.
    note_ok   = (code_q != 3'd0) &&
                (32'(len) >= LEN_MIN) &&
                (32'(len) <= LEN_MAX) &&
                (len != 8'hFF);
    accept    = (state == S_PRESENT) && ia_valid && ack;
    rej_done  = (state == S_REJECT) && (rcnt == REJ_LAST);
    total_sum = {1'b0, total} + {5'd0, IA};
    total_acc = total_sum[14] ? 14'h3FFF : total_sum[13:0];
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      len      <= '0;
      code_q   <= '0;
      rcnt     <= '0;
      prev_low <= 1'b0;
      IA       <= '0;
      ia_valid <= 1'b0;
      reject   <= 1'b0;
      note_cnt <= '0;
      rej_cnt  <= '0;
      total    <= '0;
    end else begin
      prev_low <= ~note_sense;

      case (state)
        S_IDLE: begin
          if (enable && note_sense && prev_low) begin
            len <= 8'd1;
            if (DEB <= 1) begin
              code_q <= note_code;
              state  <= S_MEASURE;
            end else begin
              state  <= S_DEBOUNCE;
            end
          end
        end

        S_DEBOUNCE: begin
          if (note_sense) begin
            len <= len_inc;
            if (32'(len_inc) >= DEB) begin
              code_q <= note_code;
              state  <= S_MEASURE;
            end
          end else begin
            // Glitch shorter than the debounce window: drop it silently.
            len   <= '0;
            state <= S_IDLE;
          end
        end

        S_MEASURE: begin
          if (note_sense) begin
            len <= len_inc;
          end else begin
            state <= S_CLASSIFY;
          end
        end

        S_CLASSIFY: begin
          len <= '0;
          if (note_ok) begin
            IA       <= decode(code_q);
            ia_valid <= 1'b1;
            state    <= S_PRESENT;
          end else begin
            reject <= 1'b1;
            rcnt   <= '0;
            state  <= S_REJECT;
          end
        end

        S_PRESENT: begin
          // ack takes priority over enable dropping in the same cycle.
          if (ack) begin
            IA       <= '0;
            ia_valid <= 1'b0;
            state    <= S_IDLE;
          end else if (!enable) begin
            IA       <= '0;
            ia_valid <= 1'b0;
            reject   <= 1'b1;
            rcnt     <= '0;
            state    <= S_REJECT;
          end
        end

        S_REJECT: begin
          if (rcnt == REJ_LAST) begin
            reject <= 1'b0;
            state  <= S_IDLE;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      // clr wipes the session; an event on the same edge is kept as the
      // first event of the new session.
      if (clr) begin
        note_cnt <= accept   ? 8'd1          : 8'd0;
        total    <= accept   ? {4'd0, IA}    : 14'd0;
        rej_cnt  <= rej_done ? 8'd1          : 8'd0;
      end else begin
        if (accept) begin
          note_cnt <= note_cnt + 8'd1;
          total    <= total_acc;
        end
        if (rej_done) begin
          rej_cnt <= rej_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_acceptor.sv
module tb_note_acceptor;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        note_sense;
  logic [2:0]  note_code;
  logic        ack;
  logic        clr;
  logic [9:0]  IA;
  logic        ia_valid;
  logic        reject;
  logic        busy;
  logic [7:0]  note_cnt;
  logic [7:0]  rej_cnt;
  logic [13:0] total;

  int compared;
  int mismatched;

  note_acceptor #(
    .DEB(4),
    .LEN_MIN(40),
    .LEN_MAX(200),
    .REJ_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .note_sense(note_sense),
    .note_code(note_code),
    .ack(ack),
    .clr(clr),
    .IA(IA),
    .ia_valid(ia_valid),
    .reject(reject),
    .busy(busy),
    .note_cnt(note_cnt),
    .rej_cnt(rej_cnt),
    .total(total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are observed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a note of n high samples, then one low sample (edge k).
  // Leaves the DUT in CLASSIFY for a correctly sized debounce.
  task automatic run_note(input logic [2:0] code, input int unsigned n);
    note_code  = code;
    note_sense = 1'b1;
    for (int unsigned i = 0; i < n; i++) tick();
    note_sense = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; note_sense = 1'b0; note_code = 3'd0;
    ack = 1'b0; clr = 1'b0;
    #2;
    compared++;
    if ({IA, ia_valid, reject, busy, note_cnt, rej_cnt, total} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got IA=%0d v=%0b rej=%0b busy=%0b nc=%0d rc=%0d tot=%0d, expected all 0",
               IA, ia_valid, reject, busy, note_cnt, rej_cnt, total);
    end
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release_idle: busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_enable_gate();
    enable = 1'b0; note_code = 3'd5; note_sense = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL disabled_ignored: busy=%0b expected 0", busy);
    end
    enable = 1'b1;  // note already in the slot when enable rises
    for (int i = 0; i < 10; i++) tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL held_at_enable_ignored: busy=%0b expected 0", busy);
    end
    note_sense = 1'b0;
    tick(); tick();
  endtask

  task automatic test_valid_note();
    run_note(3'd5, 100);  // edge k: CLASSIFY
    compared++;
    if (ia_valid !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL valid_edge_k: ia_valid=%0b busy=%0b expected 0 1", ia_valid, busy);
    end
    tick();  // edge k+1
    compared++;
    if (ia_valid !== 1'b1 || IA !== 10'd100) begin
      mismatched++;
      $display("FAIL valid_present: ia_valid=%0b IA=%0d expected 1 100", ia_valid, IA);
    end
    tick(); tick();
    compared++;
    if (ia_valid !== 1'b1 || IA !== 10'd100 || note_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL valid_hold: ia_valid=%0b IA=%0d nc=%0d expected 1 100 0", ia_valid, IA, note_cnt);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    compared++;
    if (ia_valid !== 1'b0 || IA !== 10'd0 || note_cnt !== 8'd1 || total !== 14'd100 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL valid_ack: v=%0b IA=%0d nc=%0d tot=%0d busy=%0b expected 0 0 1 100 0",
               ia_valid, IA, note_cnt, total, busy);
    end
    tick();
  endtask

  task automatic test_glitch();
    note_code = 3'd5; note_sense = 1'b1;
    tick(); tick(); tick();
    note_sense = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b0 || reject !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch_idle: busy=%0b reject=%0b expected 0 0", busy, reject);
    end
    tick(); tick();
    compared++;
    if (reject !== 1'b0 || ia_valid !== 1'b0 || note_cnt !== 8'd1 || rej_cnt !== 8'd0 || total !== 14'd100) begin
      mismatched++;
      $display("FAIL glitch_counters: rej=%0b v=%0b nc=%0d rc=%0d tot=%0d expected 0 0 1 0 100",
               reject, ia_valid, note_cnt, rej_cnt, total);
    end
  endtask

  // Bad note (short or code 0) followed by the full ejection.
  task automatic test_reject(input logic [2:0] code, input int unsigned n,
                             input logic [7:0] exp_rc);
    int hi;
    int seen_valid;
    run_note(code, n);
    tick();  // edge k+1
    compared++;
    if (reject !== 1'b1) begin
      mismatched++;
      $display("FAIL reject_rise code=%0d len=%0d: reject=%0b expected 1", code, n, reject);
    end
    hi = (reject === 1'b1) ? 1 : 0;
    seen_valid = (ia_valid === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20 && reject === 1'b1; i++) begin
      tick();
      if (reject === 1'b1) hi++;
      if (ia_valid === 1'b1) seen_valid = 1;
    end
    compared++;
    if (hi != 8 || seen_valid != 0) begin
      mismatched++;
      $display("FAIL reject_width code=%0d: high=%0d valid_seen=%0d expected 8 0", code, hi, seen_valid);
    end
    compared++;
    if (rej_cnt !== exp_rc || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reject_count code=%0d: rc=%0d busy=%0b expected %0d 0", code, rej_cnt, busy, exp_rc);
    end
    tick();
  endtask

  task automatic test_escrow_return();
    int hi;
    run_note(3'd6, 60);
    tick();
    compared++;
    if (ia_valid !== 1'b1 || IA !== 10'd500) begin
      mismatched++;
      $display("FAIL escrow_present: v=%0b IA=%0d expected 1 500", ia_valid, IA);
    end
    enable = 1'b0;
    tick();
    compared++;
    if (ia_valid !== 1'b0 || IA !== 10'd0 || reject !== 1'b1) begin
      mismatched++;
      $display("FAIL escrow_drop: v=%0b IA=%0d rej=%0b expected 0 0 1", ia_valid, IA, reject);
    end
    hi = (reject === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20 && reject === 1'b1; i++) begin
      tick();
      if (reject === 1'b1) hi++;
    end
    compared++;
    if (hi != 8 || rej_cnt !== 8'd3 || total !== 14'd100 || note_cnt !== 8'd1) begin
      mismatched++;
      $display("FAIL escrow_return: high=%0d rc=%0d tot=%0d nc=%0d expected 8 3 100 1",
               hi, rej_cnt, total, note_cnt);
    end
    enable = 1'b1;
    tick();
    run_note(3'd6, 60);
    tick();
    ack = 1'b1; enable = 1'b0;  // ack and enable drop together
    tick();
    ack = 1'b0; enable = 1'b1;
    compared++;
    if (ia_valid !== 1'b0 || reject !== 1'b0 || note_cnt !== 8'd2 || total !== 14'd600 || rej_cnt !== 8'd3) begin
      mismatched++;
      $display("FAIL ack_beats_disable: v=%0b rej=%0b nc=%0d tot=%0d rc=%0d expected 0 0 2 600 3",
               ia_valid, reject, note_cnt, total, rej_cnt);
    end
    tick();
  endtask

  task automatic test_saturation();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    compared++;
    if (note_cnt !== 8'd0 || rej_cnt !== 8'd0 || total !== 14'd0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL clr: nc=%0d rc=%0d tot=%0d busy=%0b expected 0 0 0 0", note_cnt, rej_cnt, total, busy);
    end
    for (int n = 1; n <= 17; n++) begin
      run_note(3'd7, 50);
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      if (n == 16) begin
        compared++;
        if (total !== 14'd16000 || note_cnt !== 8'd16) begin
          mismatched++;
          $display("FAIL total_16: tot=%0d nc=%0d expected 16000 16", total, note_cnt);
        end
      end
      tick();
    end
    compared++;
    if (total !== 14'd16383 || note_cnt !== 8'd17) begin
      mismatched++;
      $display("FAIL total_sat: tot=%0d nc=%0d expected 16383 17", total, note_cnt);
    end
    run_note(3'd7, 50);
    tick();
    ack = 1'b1; clr = 1'b1;
    tick();
    ack = 1'b0; clr = 1'b0;
    compared++;
    if (note_cnt !== 8'd1 || total !== 14'd1000 || rej_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL clr_with_ack: nc=%0d tot=%0d rc=%0d expected 1 1000 0", note_cnt, total, rej_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_note();
    note_code = 3'd5; note_sense = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_note_busy: busy=%0b expected 1", busy);
    end
    #2 rst = 1'b0;  // asserted between edges
    #1;
    compared++;
    if ({IA, ia_valid, reject, busy, note_cnt, rej_cnt, total} !== '0) begin
      mismatched++;
      $display("FAIL async_reset: IA=%0d v=%0b rej=%0b busy=%0b nc=%0d rc=%0d tot=%0d expected all 0",
               IA, ia_valid, reject, busy, note_cnt, rej_cnt, total);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL held_after_reset: busy=%0b expected 0", busy);
    end
    note_sense = 1'b0;
    tick();
    run_note(3'd3, 45);
    tick();
    compared++;
    if (ia_valid !== 1'b1 || IA !== 10'd20) begin
      mismatched++;
      $display("FAIL after_reset_note: v=%0b IA=%0d expected 1 20", ia_valid, IA);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    compared++;
    if (note_cnt !== 8'd1 || total !== 14'd20 || rej_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL after_reset_count: nc=%0d tot=%0d rc=%0d expected 1 20 0", note_cnt, total, rej_cnt);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_enable_gate();
    test_valid_note();
    test_glitch();
    test_reject(3'd7, 30, 8'd1);
    test_reject(3'd0, 100, 8'd2);
    test_escrow_return();
    test_saturation();
    test_reset_mid_note();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
